page_stream_loader: RTL and testbench



---
 rtl/page_stream_loader.sv | 144 ++++++++++++++
 tb/tb_page_stream_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/page_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : page_stream_loader
//  Description : Walks the page memory turn by turn, issuing synchronous reads
//                and forwarding each returned word as a one-cycle load pulse
//                for the per-page state register. Pauses between turns until
//                the downstream stage acknowledges with next_turn.
//  Revision    : 1.0 - initial release
// ============================================================================
module page_stream_loader #(
    parameter int WORD_LENGTH = 25,
    parameter int NUM_PAGE    = 64,
    parameter int NUM_TURNS   = 24,
    parameter int PAGE_BITS   = 6,
    parameter int TURN_BITS   = 5,
    parameter int ADDR_W      = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   next_turn,
    input  logic [WORD_LENGTH-1:0] mem_data_in,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [WORD_LENGTH-1:0] data_out,
    output logic                   ld_out,
    output logic [PAGE_BITS-1:0]   page_idx,
    output logic [TURN_BITS-1:0]   turn,
    output logic                   turn_done,
    output logic                   busy,
    output logic                   done
);

    localparam logic [PAGE_BITS-1:0] c_LAST_PAGE = PAGE_BITS'(NUM_PAGE - 1);
    localparam logic [TURN_BITS-1:0] c_LAST_TURN = TURN_BITS'(NUM_TURNS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PAGE_BITS-1:0]   r_page;
    logic [PAGE_BITS-1:0]   w_page_next;
    logic [TURN_BITS-1:0]   r_turn;
    logic [TURN_BITS-1:0]   w_turn_next;
    logic                   w_rd;
    logic                   w_last_page;

    // Read-return pipeline registers
    logic                   r_ld;
    logic                   r_turn_done;
    logic [PAGE_BITS-1:0]   r_ld_page;
    logic [WORD_LENGTH-1:0] r_hold;

    assign w_last_page = (r_page == c_LAST_PAGE);

    // State and page/turn counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= '0;
            r_turn  <= '0;
        end else begin
            r_state <= w_state_next;
            r_page  <= w_page_next;
            r_turn  <= w_turn_next;
        end
    end

    // Next-state logic; a read is issued on every STREAM cycle
    always_comb begin
        w_state_next = r_state;
        w_page_next  = r_page;
        w_turn_next  = r_turn;
        w_rd         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_STREAM;
                    w_page_next  = '0;
                    w_turn_next  = '0;
                end
            end
            S_STREAM: begin
                w_rd        = 1'b1;
                w_page_next = r_page + PAGE_BITS'(1);
                if (w_last_page) begin
                    w_page_next  = '0;
                    w_state_next = (r_turn == c_LAST_TURN) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (next_turn) begin
                    w_turn_next  = r_turn + TURN_BITS'(1);
                    w_page_next  = '0;
                    w_state_next = S_STREAM;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Track each read one cycle forward so the load pulse lines up with the
    // memory's data; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld        <= 1'b0;
            r_turn_done <= 1'b0;
            r_ld_page   <= '0;
            r_hold      <= '0;
        end else begin
            r_ld        <= w_rd;
            r_turn_done <= w_rd & w_last_page;
            if (w_rd) begin
                r_ld_page <= r_page;
            end
            if (r_ld) begin
                r_hold <= mem_data_in;
            end
        end
    end

    // Memory data passes straight through on the load cycle and is held after
    assign data_out  = r_ld ? mem_data_in : r_hold;
    assign ld_out    = r_ld;
    assign page_idx  = r_ld_page;
    assign turn_done = r_turn_done;
    assign mem_rd    = w_rd;
    assign mem_addr  = w_rd ? {r_turn, r_page} : '0;
    assign turn      = r_turn;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_page_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_page_stream_loader
//  Description : Self-checking bench for page_stream_loader. A synchronous
//                memory model returns address+1 one cycle after each read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_page_stream_loader;

    localparam int c_WL = 25;

    logic            clk;
    logic            rst;
    logic            start;
    logic            next_turn;
    logic [c_WL-1:0] mem_data_in;
    logic            mem_rd;
    logic [10:0]     mem_addr;
    logic [c_WL-1:0] data_out;
    logic            ld_out;
    logic [5:0]      page_idx;
    logic [4:0]      turn;
    logic            turn_done;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;

    page_stream_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .next_turn   (next_turn),
        .mem_data_in (mem_data_in),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .data_out    (data_out),
        .ld_out      (ld_out),
        .page_idx    (page_idx),
        .turn        (turn),
        .turn_done   (turn_done),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: word at address a holds a+1
    always @(posedge clk) begin
        if (mem_rd) mem_data_in <= c_WL'(mem_addr) + c_WL'(1);
    end

    // Count load pulses away from the active edge
    always @(negedge clk) begin
        if (ld_out === 1'b1) ld_cnt = ld_cnt + 1;
    end

    typedef struct {
        logic            rst;
        logic            start;
        logic            nt;
        logic            e_rd;
        logic [10:0]     e_addr;
        logic            e_ld;
        logic [c_WL-1:0] e_data;
        logic [5:0]      e_page;
        logic [4:0]      e_turn;
        logic            e_busy;
        logic            e_td;
        logic            e_done;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " mem_rd"},    32'(mem_rd),    32'd0);
        chk({tag, " mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, " ld_out"},    32'(ld_out),    32'd0);
        chk({tag, " data_out"},  32'(data_out),  32'd0);
        chk({tag, " page_idx"},  32'(page_idx),  32'd0);
        chk({tag, " turn"},      32'(turn),      32'd0);
        chk({tag, " turn_done"}, 32'(turn_done), 32'd0);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
    endtask

    // One complete 24-turn run; hold0 extra WAIT cycles before the first ack
    task automatic run_full(input bit hold_start, input int hold0, input bit stray);
        int cnt0;
        cnt0 = ld_cnt;
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        for (int t = 0; t < 24; t++) begin
            for (int p = 0; p < 64; p++) begin
                chk($sformatf("run t%0d p%0d mem_rd", t, p), 32'(mem_rd), 32'd1);
                chk($sformatf("run t%0d p%0d mem_addr", t, p), 32'(mem_addr), 32'(t * 64 + p));
                chk($sformatf("run t%0d p%0d turn", t, p), 32'(turn), 32'(t));
                chk($sformatf("run t%0d p%0d busy", t, p), 32'(busy), 32'd1);
                if (p == 0) begin
                    chk($sformatf("run t%0d p0 ld_out", t), 32'(ld_out), 32'd0);
                end else begin
                    chk($sformatf("run t%0d p%0d ld_out", t, p), 32'(ld_out), 32'd1);
                    chk($sformatf("run t%0d p%0d data_out", t, p), 32'(data_out), 32'(t * 64 + p));
                    chk($sformatf("run t%0d p%0d page_idx", t, p), 32'(page_idx), 32'(p - 1));
                    chk($sformatf("run t%0d p%0d turn_done", t, p), 32'(turn_done), 32'd0);
                    chk($sformatf("run t%0d p%0d done", t, p), 32'(done), 32'd0);
                end
                next_turn = stray && (p == 20);
                step();
            end
            next_turn = 1'b0;
            chk($sformatf("end t%0d ld_out", t), 32'(ld_out), 32'd1);
            chk($sformatf("end t%0d data_out", t), 32'(data_out), 32'(t * 64 + 64));
            chk($sformatf("end t%0d page_idx", t), 32'(page_idx), 32'd63);
            chk($sformatf("end t%0d turn_done", t), 32'(turn_done), 32'd1);
            chk($sformatf("end t%0d mem_rd", t), 32'(mem_rd), 32'd0);
            chk($sformatf("end t%0d busy", t), 32'(busy), 32'd1);
            chk($sformatf("end t%0d done", t), 32'(done), (t == 23) ? 32'd1 : 32'd0);
            if (t < 23) begin
                for (int h = 0; h < ((t == 0) ? hold0 : 0); h++) begin
                    step();
                    chk($sformatf("hold t%0d h%0d mem_rd", t, h), 32'(mem_rd), 32'd0);
                    chk($sformatf("hold t%0d h%0d ld_out", t, h), 32'(ld_out), 32'd0);
                    chk($sformatf("hold t%0d h%0d busy", t, h), 32'(busy), 32'd1);
                    chk($sformatf("hold t%0d h%0d turn", t, h), 32'(turn), 32'(t));
                end
                next_turn = 1'b1;
                step();
                next_turn = 1'b0;
            end else begin
                step();
                chk("post-run busy", 32'(busy), 32'd0);
                chk("post-run done", 32'(done), 32'd0);
                chk("post-run mem_rd", 32'(mem_rd), 32'd0);
                chk("post-run ld_out", 32'(ld_out), 32'd0);
                start = 1'b0;
                step();
                chk("idle stays busy=0", 32'(busy), 32'd0);
                chk("idle stays mem_rd=0", 32'(mem_rd), 32'd0);
            end
        end
        chk("ld_out pulse count", 32'(ld_cnt - cnt0), 32'd1536);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        next_turn = 1'b0;

        //           rst  st   nt   rd   addr   ld   data  pg  trn  busy td   done
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 25'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 25'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 25'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 25'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 11'd1, 1'b1, 25'd1, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 11'd2, 1'b1, 25'd2, 6'd1, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 11'd3, 1'b1, 25'd3, 6'd2, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 25'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 25'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            rst       = vecs[i].rst;
            start     = vecs[i].start;
            next_turn = vecs[i].nt;
            step();
            chk($sformatf("vec%0d mem_rd", i),    32'(mem_rd),    32'(vecs[i].e_rd));
            chk($sformatf("vec%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
            chk($sformatf("vec%0d ld_out", i),    32'(ld_out),    32'(vecs[i].e_ld));
            chk($sformatf("vec%0d data_out", i),  32'(data_out),  32'(vecs[i].e_data));
            chk($sformatf("vec%0d page_idx", i),  32'(page_idx),  32'(vecs[i].e_page));
            chk($sformatf("vec%0d turn", i),      32'(turn),      32'(vecs[i].e_turn));
            chk($sformatf("vec%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
            chk($sformatf("vec%0d turn_done", i), 32'(turn_done), 32'(vecs[i].e_td));
            chk($sformatf("vec%0d done", i),      32'(done),      32'(vecs[i].e_done));
        end
        start     = 1'b0;
        next_turn = 1'b0;

        // Full run with a 10-cycle hold in the first WAIT, then immediate acks
        run_full(1'b0, 10, 1'b0);

        // start held high throughout, stray next_turn pulses mid-STREAM
        run_full(1'b1, 0, 1'b1);

        // Reset while the read of address 30 is in flight
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("pre-rst mem_rd", 32'(mem_rd), 32'd1);
        chk("pre-rst mem_addr", 32'(mem_addr), 32'd30);
        rst = 1'b1;
        step();
        chk_idle("rst-mid");
        rst = 1'b0;
        step();
        chk_idle("after-rst");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart mem_rd", 32'(mem_rd), 32'd1);
        chk("restart mem_addr", 32'(mem_addr), 32'd0);
        chk("restart turn", 32'(turn), 32'd0);
        step();
        chk("restart ld_out", 32'(ld_out), 32'd1);
        chk("restart data_out", 32'(data_out), 32'd1);
        chk("restart page_idx", 32'(page_idx), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
